// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the error codes returned on the response channel, the
// controller state encoding, and the width of the wait-state counter.
package dmem_pkg;

    // Wide enough for wait-state counts up to 15.
    localparam int WAIT_CNT_W = 4;

    // Status returned with every response.
    typedef enum logic [1:0] {
        DMEM_OK         = 2'b00,
        DMEM_MISALIGNED = 2'b01,
        DMEM_RANGE      = 2'b10
    } dmem_err_t;

    // Controller states: waiting for a request, counting wait states,
    // presenting a response.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_t;

endpackage : dmem_pkg

// File: rtl/dmem_ram_array.sv
// Single-port word array, DEPTH_WORDS x 32, with per-byte write enables
// and a synchronous read port. Each byte lane is its own array so that a
// partial store never needs a read-modify-write. Contents are not reset.
module dmem_ram_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clock,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_q [DEPTH_WORDS];
            logic [7:0] rd_q;

            // Byte-lane write on its enable; read data registered only when
            // a read is issued, so it holds steady while a response waits.
            always_ff @(posedge clock) begin
                if (we && be[gi]) begin
                    lane_q[addr] <= wdata[8*gi +: 8];
                end
                if (re) begin
                    rd_q <= lane_q[addr];
                end
            end

            assign rdata[8*gi +: 8] = rd_q;
        end
    endgenerate

endmodule : dmem_ram_array

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data-memory request port.
// Accepts one word-aligned load/store at a time, waits WAIT_STATES cycles,
// then returns load data and an error status on the response channel.
// Optional build macro DMEM_ACCESS_COUNTERS_EN adds saturating load,
// store and error counters as extra output ports.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err
`ifdef DMEM_ACCESS_COUNTERS_EN
    ,
    output logic [31:0] load_count,
    output logic [31:0] store_count,
    output logic [15:0] err_count
`endif
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

    // Controller registers
    dmem_state_t           state_q;
    logic [WAIT_CNT_W-1:0] cnt_q;
    logic                  we_q;
    logic [AW-1:0]         idx_q;
    dmem_err_t             err_q;
    dmem_err_t             rsp_err_q;
    logic                  rsp_valid_q;
    logic                  rdata_sel_q;

    // Request decode and array control
    logic [31:0]   req_offset;
    logic [AW-1:0] req_idx;
    dmem_err_t     req_err;
    logic          accept;
    logic          enter_resp;
    logic          cur_load_ok;
    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata;

    // Offset is a plain 32-bit subtraction; underflow is caught by the
    // explicit below-base compare rather than being allowed to wrap.
    assign req_offset = req_addr - BASE_ADDR;
    assign req_idx    = req_offset[AW+1:2];

    // Classify the incoming request; misalignment wins over range.
    always_comb begin
        req_err = DMEM_OK;
        if (req_addr[1:0] != 2'b00) begin
            req_err = DMEM_MISALIGNED;
        end else if ((req_addr < BASE_ADDR) ||
                     ((req_offset >> 2) >= 32'(DEPTH_WORDS))) begin
            req_err = DMEM_RANGE;
        end
    end

    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // The array read is issued on the edge that enters RESP, so the RAM
    // output register itself is the captured load data.
    assign enter_resp  = ((state_q == IDLE) && accept && (WAIT_STATES == 0)) ||
                         ((state_q == WAIT) && (cnt_q == CNT_ONE));
    assign cur_load_ok = (state_q == IDLE) ? (!req_we && (req_err == DMEM_OK))
                                           : (!we_q && (err_q == DMEM_OK));
    assign ram_we      = accept && req_we && (req_err == DMEM_OK);
    assign ram_re      = enter_resp && cur_load_ok;
    assign ram_addr    = (state_q == IDLE) ? req_idx : idx_q;

    dmem_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .be    (req_be),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (req_wdata),
        .rdata (ram_rdata)
    );

    // Request/response controller with registered response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            err_q       <= DMEM_OK;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= DMEM_OK;
            rdata_sel_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q  <= req_we;
                        idx_q <= req_idx;
                        err_q <= req_err;
                        if (WAIT_STATES == 0) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= req_err;
                            rdata_sel_q <= cur_load_ok;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_q;
                        rdata_sel_q <= cur_load_ok;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= DMEM_OK;
                        rdata_sel_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rdata_sel_q ? ram_rdata : 32'h0;

`ifdef DMEM_ACCESS_COUNTERS_EN
    logic [31:0] load_cnt_q;
    logic [31:0] store_cnt_q;
    logic [15:0] err_cnt_q;

    // Saturating per-type access counters, bumped on the accept edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (accept) begin
            if (req_err != DMEM_OK) begin
                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 16'd1;
            end else if (req_we) begin
                if (store_cnt_q != '1) store_cnt_q <= store_cnt_q + 32'd1;
            end else begin
                if (load_cnt_q != '1) load_cnt_q <= load_cnt_q + 32'd1;
            end
        end
    end

    assign load_count  = load_cnt_q;
    assign store_count = store_cnt_q;
    assign err_count   = err_cnt_q;
`endif

endmodule : dmem_responder
